mul_div_unit: RTL and testbench

Parametrised iterative multiply/divide co-processor for the Nios II system. It is the hardware successor to the exported a/b → produto/quociente/resto datapath. It adds a start/busy/done handshake, a selectable operation, signed or unsigned mode, a configurable operand width and division-by-zero reporting. One shift-add or shift-subtract step is executed per clock; it sits behind PIO or Avalon glue in the top-level system.

---
 rtl/mul_div_pkg.sv | 14 +
 rtl/mul_div_core.sv | 40 ++++
 rtl/mul_div_unit.sv | 130 +++++++++++++
 tb/tb_mul_div_unit.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mul_div_pkg.sv
// rtl/mul_div_pkg.sv - shared constants for the iterative multiply/divide unit
package mul_div_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t CALC = 2'd1;
  localparam state_t FIX  = 2'd2;
  localparam state_t DONE = 2'd3;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

endpackage

// File: rtl/mul_div_core.sv
// rtl/mul_div_core.sv - one shift-add / restoring shift-subtract step
module mul_div_core
  import mul_div_pkg::*;
#(
  parameter int WIDTH = 32
)
(
  input  logic               op,
  input  logic [2*WIDTH:0]   acc_in,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH:0]   acc_out
);

  // Multiply keeps {carry, upper, multiplier} in acc; divide keeps {remainder, quotient}.
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;

  // Single iteration: conditional add then shift right, or shift left then trial subtract.
  always_comb begin
    sum     = acc_in[2*WIDTH:WIDTH] + {1'b0, operand};
    shifted = acc_in[2*WIDTH-1:WIDTH-1];
    diff    = {1'b0, shifted} - {2'b00, operand};
    acc_out = acc_in;
    if (op == OP_MUL) begin
      if (acc_in[0]) begin
        acc_out = {1'b0, sum, acc_in[WIDTH-1:1]};
      end else begin
        acc_out = {1'b0, acc_in[2*WIDTH:1]};
      end
    end else begin
      if (diff[WIDTH+1]) begin
        acc_out = {shifted, acc_in[WIDTH-2:0], 1'b0};
      end else begin
        acc_out = {diff[WIDTH:0], acc_in[WIDTH-2:0], 1'b1};
      end
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative multiply/divide co-processor with start/busy/done handshake
module mul_div_unit
  import mul_div_pkg::*;
#(
  parameter int WIDTH = 32
)
(
  input  logic                 clk_clk,
  input  logic                 reset_reset,
  input  logic                 start,
  input  logic                 op,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   produto,
  output logic [WIDTH-1:0]     quociente,
  output logic [WIDTH-1:0]     resto,
  output logic                 div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [2*WIDTH:0]     acc;
  logic [2*WIDTH:0]     acc_next;
  logic [WIDTH-1:0]     operand;
  logic                 op_q;
  logic                 neg_main;
  logic                 neg_rem;
  logic [WIDTH-1:0]     mag_a;
  logic [WIDTH-1:0]     mag_b;
  logic                 accept;
  logic                 zero_div;

  // MIN negates to itself, which read unsigned is exactly its magnitude.
  assign mag_a    = (signed_mode && a[WIDTH-1]) ? -a : a;
  assign mag_b    = (signed_mode && b[WIDTH-1]) ? -b : b;
  assign accept   = (state == IDLE) && start;
  assign zero_div = (op == OP_DIV) && (b == '0);

  assign busy = (state == CALC) || (state == FIX);
  assign done = (state == DONE);

  mul_div_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .op      (op_q),
    .acc_in  (acc),
    .operand (operand),
    .acc_out (acc_next)
  );

  // Sequencer: capture operands on start, iterate WIDTH steps, then fix signs.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      operand  <= '0;
      op_q     <= OP_MUL;
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q     <= op;
            neg_main <= signed_mode && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_rem  <= signed_mode && a[WIDTH-1];
            cnt      <= CNT_W'(WIDTH - 1);
            if (op == OP_MUL) begin
              acc     <= {{(WIDTH+1){1'b0}}, mag_b};
              operand <= mag_a;
            end else begin
              acc     <= {{(WIDTH+1){1'b0}}, mag_a};
              operand <= mag_b;
            end
            state <= zero_div ? DONE : CALC;
          end
        end
        CALC: begin
          acc <= acc_next;
          cnt <= cnt - CNT_W'(1);
          if (cnt == '0) begin
            state <= FIX;
          end
        end
        FIX: begin
          state <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Result registers: hold until the next sign fix or divide-by-zero shortcut.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      produto     <= '0;
      quociente   <= '0;
      resto       <= '0;
      div_by_zero <= 1'b0;
    end else begin
      if (accept) begin
        div_by_zero <= zero_div;
        if (zero_div) begin
          quociente <= '1;
          resto     <= a;
        end
      end
      if (state == FIX) begin
        if (op_q == OP_MUL) begin
          produto <= neg_main ? -acc[2*WIDTH-1:0] : acc[2*WIDTH-1:0];
        end else begin
          quociente <= neg_main ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
          resto     <= neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        end
      end
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - directed self-checking bench for mul_div_unit
module tb_mul_div_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // WIDTH=8 instance
  logic        rst8, start8, op8, sm8, busy8, done8, dbz8;
  logic [7:0]  a8, b8, quo8, rem8;
  logic [15:0] prod8;

  // WIDTH=16 instance
  logic        rst16, start16, op16, sm16, busy16, done16, dbz16;
  logic [15:0] a16, b16, quo16, rem16;
  logic [31:0] prod16;

  // WIDTH=32 instance
  logic        rst32, start32, op32, sm32, busy32, done32, dbz32;
  logic [31:0] a32, b32, quo32, rem32;
  logic [63:0] prod32;

  mul_div_unit #(.WIDTH(8)) u_dut8 (
    .clk_clk(clk), .reset_reset(rst8), .start(start8), .op(op8), .signed_mode(sm8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .produto(prod8), .quociente(quo8),
    .resto(rem8), .div_by_zero(dbz8)
  );

  mul_div_unit #(.WIDTH(16)) u_dut16 (
    .clk_clk(clk), .reset_reset(rst16), .start(start16), .op(op16), .signed_mode(sm16),
    .a(a16), .b(b16), .busy(busy16), .done(done16), .produto(prod16), .quociente(quo16),
    .resto(rem16), .div_by_zero(dbz16)
  );

  mul_div_unit #(.WIDTH(32)) u_dut32 (
    .clk_clk(clk), .reset_reset(rst32), .start(start32), .op(op32), .signed_mode(sm32),
    .a(a32), .b(b32), .busy(busy32), .done(done32), .produto(prod32), .quociente(quo32),
    .resto(rem32), .div_by_zero(dbz32)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Issue one op on the 8-bit unit; lat is the cycle (after the start edge) where done is seen.
  task automatic run8(input logic o, input logic s, input logic [7:0] x, input logic [7:0] y,
                      output int lat, output int nbusy);
    @(negedge clk);
    op8 = o; sm8 = s; a8 = x; b8 = y; start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0; a8 = ~x; b8 = ~y; op8 = ~o; sm8 = ~s;
    lat = -1; nbusy = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (busy8) nbusy++;
      if (done8) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic run16(input logic o, input logic [15:0] x, input logic [15:0] y, output int lat);
    @(negedge clk);
    op16 = o; sm16 = 1'b0; a16 = x; b16 = y; start16 = 1'b1;
    @(posedge clk);
    #1;
    start16 = 1'b0; a16 = 16'hdead; b16 = 16'hbeef;
    lat = -1;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (done16) begin
        lat = n;
        break;
      end
    end
  endtask

  initial begin
    int lat, nb, dn;
    rst8 = 1'b1;  start8 = 1'b0;  op8 = 1'b0;  sm8 = 1'b0;  a8 = '0;  b8 = '0;
    rst16 = 1'b1; start16 = 1'b0; op16 = 1'b0; sm16 = 1'b0; a16 = '0; b16 = '0;
    rst32 = 1'b1; start32 = 1'b0; op32 = 1'b0; sm32 = 1'b0; a32 = '0; b32 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst busy", busy8, 0);
    check("rst done", done8, 0);
    check("rst dbz", dbz8, 0);
    check("rst prod", prod8, 0);
    check("rst quo", quo8, 0);
    check("rst rem", rem8, 0);
    rst8 = 1'b0; rst16 = 1'b0; rst32 = 1'b0;

    // unsigned multiply 200*150
    run8(1'b0, 1'b0, 8'd200, 8'd150, lat, nb);
    check("umul lat", lat, 10);
    check("umul busy cycles", nb, 9);
    check("umul prod", prod8, 16'd30000);
    check("umul quo held", quo8, 0);
    check("umul rem held", rem8, 0);

    // unsigned divide 250/7
    run8(1'b1, 1'b0, 8'd250, 8'd7, lat, nb);
    check("udiv lat", lat, 10);
    check("udiv quo", quo8, 8'd35);
    check("udiv rem", rem8, 8'd5);
    check("udiv dbz", dbz8, 0);
    check("udiv prod held", prod8, 16'd30000);

    // signed divide -7/2
    run8(1'b1, 1'b1, 8'hF9, 8'd2, lat, nb);
    check("sdiv quo", quo8, 8'hFD);
    check("sdiv rem", rem8, 8'hFF);

    // signed multiply -128*-128
    run8(1'b0, 1'b1, 8'h80, 8'h80, lat, nb);
    check("smul min prod", prod8, 16'd16384);

    // divide by zero
    run8(1'b1, 1'b0, 8'h5A, 8'h00, lat, nb);
    check("dbz lat", lat, 1);
    check("dbz busy cycles", nb, 0);
    check("dbz quo", quo8, 8'hFF);
    check("dbz rem", rem8, 8'h5A);
    check("dbz flag", dbz8, 1);
    check("dbz prod held", prod8, 16'd16384);

    // next valid divide clears the flag (issued back-to-back)
    run8(1'b1, 1'b0, 8'd100, 8'd10, lat, nb);
    check("dbz clear flag", dbz8, 0);
    check("dbz clear quo", quo8, 8'd10);
    check("dbz clear rem", rem8, 8'd0);

    // signed overflow MIN / -1
    run8(1'b1, 1'b1, 8'h80, 8'hFF, lat, nb);
    check("ovf quo", quo8, 8'h80);
    check("ovf rem", rem8, 8'h00);

    // signed mixed-sign multiply and divide
    run8(1'b0, 1'b1, 8'hFD, 8'd5, lat, nb);
    check("smul neg prod", prod8, 16'hFFF1);
    run8(1'b1, 1'b1, 8'd7, 8'hFE, lat, nb);
    check("sdiv negdivisor quo", quo8, 8'hFD);
    check("sdiv negdivisor rem", rem8, 8'd1);

    // unsigned extremes
    run8(1'b0, 1'b0, 8'hFF, 8'hFF, lat, nb);
    check("umul max prod", prod8, 16'hFE01);
    run8(1'b1, 1'b0, 8'hFF, 8'h01, lat, nb);
    check("udiv by one quo", quo8, 8'hFF);
    check("udiv by one rem", rem8, 8'h00);

    // 32-bit: second start mid-CALC must be ignored
    @(negedge clk);
    op32 = 1'b0; sm32 = 1'b0; a32 = 32'd123456789; b32 = 32'd1000; start32 = 1'b1;
    @(posedge clk);
    #1;
    start32 = 1'b0;
    dn = 0; lat = -1; nb = 0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (busy32) nb++;
      if (done32) begin
        dn++;
        if (lat < 0) lat = n;
      end
      if (n == 5) begin
        start32 = 1'b1; op32 = 1'b1; sm32 = 1'b1; a32 = 32'd7; b32 = 32'd9;
      end
      if (n == 6) start32 = 1'b0;
    end
    check("w32 done count", dn, 1);
    check("w32 lat", lat, 34);
    check("w32 busy cycles", nb, 33);
    check("w32 prod", prod32, 64'h0000001C_BE991A08);
    check("w32 quo held", quo32, 0);
    check("w32 rem held", rem32, 0);

    // 16-bit: load nonzero outputs, then reset mid multiply
    run16(1'b0, 16'd300, 16'd400, lat);
    check("w16 mul lat", lat, 18);
    check("w16 mul prod", prod16, 32'd120000);
    run16(1'b1, 16'd1000, 16'd3, lat);
    check("w16 div quo", quo16, 16'd333);
    check("w16 div rem", rem16, 16'd1);
    @(negedge clk);
    op16 = 1'b0; a16 = 16'd1234; b16 = 16'd56; start16 = 1'b1;
    @(posedge clk);
    #1;
    start16 = 1'b0;
    dn = 0;
    repeat (5) begin
      @(negedge clk);
      if (done16) dn++;
    end
    check("w16 busy before reset", busy16, 1);
    rst16 = 1'b1;
    @(negedge clk);
    rst16 = 1'b0;
    check("w16 reset busy", busy16, 0);
    check("w16 reset done", done16, 0);
    check("w16 reset prod", prod16, 0);
    check("w16 reset quo", quo16, 0);
    check("w16 reset rem", rem16, 0);
    repeat (30) begin
      @(negedge clk);
      if (done16) dn++;
    end
    check("w16 no done after reset", dn, 0);
    run16(1'b0, 16'd250, 16'd4, lat);
    check("w16 restart lat", lat, 18);
    check("w16 restart prod", prod16, 32'd1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
